// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source selects, load funct3 codes and FSM states.
package wb_pkg;

    localparam logic [2:0] WB_ALU   = 3'b000;
    localparam logic [2:0] WB_LOAD  = 3'b001;
    localparam logic [2:0] WB_PC4   = 3'b010;
    localparam logic [2:0] WB_PCIMM = 3'b011;
    localparam logic [2:0] WB_IMM   = 3'b100;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the byte/halfword/word addressed by a load from the memory read word.
module load_formatter
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     mem_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] fmt_data
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign byte_c = mem_rdata[{addr_lo, 3'b000} +: 8];
    assign half_c = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3)
            F3_LB:   fmt_data = XLEN'(signed'(byte_c));
            F3_LH:   fmt_data = XLEN'(signed'(half_c));
            F3_LBU:  fmt_data = XLEN'(byte_c);
            F3_LHU:  fmt_data = XLEN'(half_c);
            default: fmt_data = XLEN'(mem_rdata);
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: selects the register-file write value, registers the write port and stalls on slow loads.
// Optional load timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [2:0]      wb_sel,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_rvalid,
    output logic            stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef WB_LOAD_TIMEOUT_EN
    ,
    output logic            timeout_err
`endif
);

    wb_state_e       state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      lo_q, lo_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [XLEN-1:0] src_c;
    logic [XLEN-1:0] fmt_c;
    logic [2:0]      fmt_f3_c;
    logic [1:0]      fmt_lo_c;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    assign timeout_err = tmo_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    // Non-load source mux; reserved select codes fall back to the ALU result.
    always_comb begin
        case (wb_sel)
            WB_PC4:   src_c = pc + XLEN'(4);
            WB_PCIMM: src_c = pc + imm;
            WB_IMM:   src_c = imm;
            default:  src_c = alu_result;
        endcase
    end

    // While waiting, the formatter must see the load's latched size and offset.
    assign fmt_f3_c = (state_q == ST_WAIT_LOAD) ? f3_q : funct3;
    assign fmt_lo_c = (state_q == ST_WAIT_LOAD) ? lo_q : addr_lo;

    load_formatter #(.XLEN(XLEN)) u_fmt (
        .mem_rdata (mem_rdata),
        .funct3    (fmt_f3_c),
        .addr_lo   (fmt_lo_c),
        .fmt_data  (fmt_c)
    );

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        stall      = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (wb_sel == WB_LOAD) begin
                        if (mem_rvalid) begin
                            rf_we_d    = (rd_addr != 5'd0);
                            rf_waddr_d = rd_addr;
                            rf_wdata_d = fmt_c;
                        end else begin
                            rd_d    = rd_addr;
                            f3_d    = funct3;
                            lo_d    = addr_lo;
                            state_d = ST_WAIT_LOAD;
                            stall   = 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end else begin
                        rf_we_d    = (rd_addr != 5'd0);
                        rf_waddr_d = rd_addr;
                        rf_wdata_d = src_c;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                if (mem_rvalid) begin
                    rf_we_d    = (rd_q != 5'd0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = fmt_c;
                    state_d    = ST_IDLE;
                end else begin
                    stall = 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
                    // Give up on the load: release the core and drop the write.
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        stall   = 1'b0;
                        tmo_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_q       <= '0;
            f3_q       <= '0;
            lo_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            lo_q       <= lo_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule
